crc16_frame_encoder: RTL and testbench
======================================

# crc16_frame_encoder

Transmit-side CRC-16-CCITT framer that sits directly upstream of the CRC-16 decoder/checker. It accepts a stream of 16-bit data words delimited by a last flag and forwards them unchanged. After the final data word of each frame it appends one computed CRC word, so the checker sees a complete data+CRC frame. Ready/valid backpressure is supported on both sides.

## Interface
- MAX_WORDS, 256 — maximum data words per frame (≥1); a frame reaching this length is force-terminated.
- CNT_W, $clog2(MAX_WORDS+1) — width of the word counter.
- clk  input  1  — single clock, rising edge.
- reset  input  1  — asynchronous, active-low reset; low clears all state immediately.
- in_data  input  16  — data word, MSB first.
- in_valid  input  1  — in_data is valid.
- in_last  input  1  — the current word is the final data word of the frame.
- in_ready  output  1  — the block accepts a word this cycle.
- out_data  output  16  — data word, or CRC word.
- out_valid  output  1  — out_data is valid.
- out_last  output  1  — set only on the appended CRC word.
- out_is_crc  output  1  — out_data carries the CRC.
- out_ready  input  1  — downstream accepts a word.
- len_err  output  1  — one-cycle pulse when a frame is force-terminated at MAX_WORDS.

## Operation
- CRC parameters: polynomial 0x1021, init 0xFFFF, no bit reflection, 16 bits processed per accepted word, MSB first.
- States:
  - IDLE: no frame in progress; the CRC register is 0xFFFF.
  - DATA: frame in progress.
  - CRC: final CRC pending output.
- Accept rule: a word is accepted when in_valid && in_ready.
- On accept:
  - The CRC register is updated with crc_next(crc, in_data).
  - The word is copied to the output register with out_is_crc=0 and out_last=0.
  - The word counter increments.
- State transitions:
  - IDLE→DATA on the first accepted word.
  - DATA or IDLE→CRC when the accepted word has in_last=1, or when it is word number MAX_WORDS.
- Forced termination: a word at MAX_WORDS with in_last=0 pulses len_err in the same cycle the word is accepted. The next input word starts a new frame.
- In CRC state:
  - in_ready=0.
  - When the output slot is free, out_data is loaded with the final CRC (XOROUT applied per Configuration), with out_is_crc=1 and out_last=1.
  - The CRC register resets to 0xFFFF, the counter clears, and the state goes to IDLE.
- Output register (single entry): holds its value while out_valid && !out_ready. Data never changes while held.
- in_ready = (state != CRC) && (!out_valid || out_ready).
- Reset mid-frame: the partial frame is discarded with no CRC emitted. All outputs return to reset values.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, out_is_crc=0, len_err=0, in_ready=0 while reset is asserted. in_ready=1 from the first cycle after release.
- Latency: an accepted word appears on out_data in the next cycle.
- Throughput:
  - A frame of N words uses N+1 output beats.
  - With out_ready held at 1, one input bubble (in_ready=0) occurs per frame, during the CRC beat.
- Simultaneous events: the output register may be drained and reloaded in the same cycle. The last data word and the CRC word therefore transfer on consecutive cycles.
- Backpressure on the CRC beat holds out_data, out_last and out_is_crc stable until out_ready.

## Configuration
- CRC16_ENC_XOROUT_EN:
  - Defined: the appended CRC is the final register XOR 0xFFFF.
  - Undefined: the raw register is appended. In this mode, running the CRC over data+CRC with init 0xFFFF yields residue 0x0000, matching the downstream checker's zero-check.

## Structure
- Shared package crc16_pkg holds:
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF, CRC16_XOROUT=16'hFFFF.
  - Enum enc_state_t {IDLE, DATA, CRC}.
  - The function crc16_word(crc, word), which the checker also reuses.
- Sub-module crc16_word_update: combinational 16-bit-per-cycle next-CRC logic (inputs crc and word, output crc_next). The framer FSM, counter and output register live in the top module.

## Test plan
- Single-word frame in_data=0x0000 with in_last=1 and out_ready=1 → out beats 0x0000 then 0x1D0F (out_last=1, out_is_crc=1). With CRC16_ENC_XOROUT_EN defined, the CRC beat is 0xE2F0.
- Frames of 1–64 random words back-to-back → the reference-model CRC matches every CRC beat. Recomputing over data+CRC gives 0x0000 (macro undefined).
- out_ready toggled randomly → no word is lost or duplicated, out_data is stable while stalled, and in_ready=0 throughout the CRC state.
- MAX_WORDS=4 with a 6-word input lacking in_last → len_err pulses on word 4, a CRC over words 1–4 is emitted, and words 5–6 form a new frame.
- Reset asserted after word 3 of a 5-word frame → outputs drop to 0 asynchronously and no CRC is emitted. The next frame 0x0000/last produces CRC 0x1D0F.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared CRC-16-CCITT definitions for the framer and the downstream checker.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   CRC16_POLY / CRC16_INIT / CRC16_XOROUT  - CCITT-FALSE parameters
//   enc_state_t                             - framer state encoding
//   crc16_word()                            - 16 bits per call, MSB first
package crc16_pkg;

   localparam logic [15:0] CRC16_POLY   = 16'h1021;
   localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
   localparam logic [15:0] CRC16_XOROUT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2
   } enc_state_t;

   // Bit-serial CRC unrolled over one 16-bit word, MSB first, no reflection.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                              input logic [15:0] word);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 15; i >= 0; i--) begin
         fb = c[15] ^ word[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_word_update.sv
// Next-state CRC-16-CCITT logic for one 16-bit word per cycle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to commit crc_next.
//
// Ports:
//   crc      - current CRC register
//   word     - data word to fold in, MSB first
//   crc_next - CRC after absorbing word
module crc16_word_update
   import crc16_pkg::*;
(
   input  logic [15:0] crc,
   input  logic [15:0] word,
   output logic [15:0] crc_next
);

   assign crc_next = crc16_word(crc, word);

endmodule

// File: rtl/crc16_frame_encoder.sv
// Transmit framer: forwards 16-bit data words and appends one CRC-16 word per frame.
// Latency: an accepted word appears on out_data one cycle later; CRC follows the last word.
// Backpressure: single-entry output register; in_ready drops while it is held or a CRC is pending.
//
// Ports:
//   clk, reset (async, active-low)
//   in_data/in_valid/in_last/in_ready     - upstream word stream, in_last marks final data word
//   out_data/out_valid/out_ready          - downstream stream, data words followed by the CRC
//   out_last, out_is_crc                  - both set only on the appended CRC word
//   len_err                               - same-cycle pulse when a frame is cut at MAX_WORDS
//
// Build option: define CRC16_ENC_XOROUT_EN to append (register ^ CRC16_XOROUT) instead of
// the raw register. With it undefined the checker sees a zero residue over data+CRC.
module crc16_frame_encoder
   import crc16_pkg::*;
#(
   parameter int MAX_WORDS = 256,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [15:0] out_data,
   output logic        out_valid,
   output logic        out_last,
   output logic        out_is_crc,
   input  logic        out_ready,
   output logic        len_err
);

   // Counter value held while the MAX_WORDS-th word of a frame is on the input.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WORDS - 1);

   enc_state_t       state;
   logic [15:0]      crc_reg;
   logic [15:0]      crc_next;
   logic [15:0]      crc_final;
   logic [CNT_W-1:0] word_cnt;

   logic slot_free;
   logic accept;
   logic at_max;
   logic terminal;

   crc16_word_update u_crc_update (
      .crc      (crc_reg),
      .word     (in_data),
      .crc_next (crc_next)
   );

`ifdef CRC16_ENC_XOROUT_EN
   assign crc_final = crc_reg ^ CRC16_XOROUT;
`else
   assign crc_final = crc_reg;
`endif

   // The output register can take a new word when empty or being drained this cycle.
   assign slot_free = !out_valid || out_ready;

   // Gating with reset keeps in_ready low while reset is held; all other terms are registered.
   assign in_ready  = reset && (state != CRC) && slot_free;
   assign accept    = in_valid && in_ready;
   assign at_max    = (word_cnt == CNT_LAST);
   assign terminal  = in_last || at_max;

   // Forced termination is flagged in the cycle the MAX_WORDS-th word is accepted.
   assign len_err   = accept && at_max && !in_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         crc_reg    <= CRC16_INIT;
         word_cnt   <= '0;
         out_data   <= 16'h0000;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_is_crc <= 1'b0;
      end else begin
         if (accept) begin
            // Data word: forward unchanged and fold into the running CRC.
            crc_reg    <= crc_next;
            word_cnt   <= word_cnt + CNT_W'(1);
            out_data   <= in_data;
            out_valid  <= 1'b1;
            out_last   <= 1'b0;
            out_is_crc <= 1'b0;
            state      <= terminal ? CRC : DATA;
         end else if ((state == CRC) && slot_free) begin
            // Append the CRC word and rearm for the next frame.
            out_data   <= crc_final;
            out_valid  <= 1'b1;
            out_last   <= 1'b1;
            out_is_crc <= 1'b1;
            crc_reg    <= CRC16_INIT;
            word_cnt   <= '0;
            state      <= IDLE;
         end else if (out_ready) begin
            // Drained with nothing to reload; payload bits are left as-is.
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_crc16_frame_encoder.sv
module tb_crc16_frame_encoder;

   localparam int MAXW = 4;
`ifdef CRC16_ENC_XOROUT_EN
   localparam logic [15:0] XO       = 16'hFFFF;
   localparam logic [15:0] HAND_Z   = 16'hE2F0;  // CRC of single word 0x0000
   localparam logic [15:0] HAND_F   = 16'hFFFF;  // CRC of single word 0xFFFF
`else
   localparam logic [15:0] XO       = 16'h0000;
   localparam logic [15:0] HAND_Z   = 16'h1D0F;
   localparam logic [15:0] HAND_F   = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] in_data = 16'h0000;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_is_crc;
   logic        len_err;

   always #5 clk = ~clk;

   crc16_frame_encoder #(.MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_is_crc (out_is_crc),
      .out_ready  (out_ready),
      .len_err    (len_err)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        last;
      logic        is_crc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          rdy_mode = 0;        // 0: always ready, 1: random, 2: stalled
   logic        crc_pending = 1'b0;
   logic [15:0] m_run = 16'hFFFF;    // stimulus-side model
   int          m_cnt = 0;
   logic [15:0] r_run = 16'hFFFF;    // running CRC over observed output beats

   // Byte-oriented CRC-16-CCITT reference (two bytes per word, high byte first).
   function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [15:0] w);
      logic [15:0] r;
      logic [7:0]  b;
      r = c;
      for (int k = 0; k < 2; k++) begin
         b = (k == 0) ? w[15:8] : w[7:0];
         r = r ^ {b, 8'h00};
         for (int j = 0; j < 8; j++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // out_ready changes shortly after each rising edge so it is stable at the falling edge.
   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic send_word(input logic [15:0] d, input logic l,
                            input logic hand_en, input logic [15:0] hand_crc);
      int   t;
      logic term;
      exp_t e;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
         in_valid = 1'b0;
         return;
      end
      m_cnt++;
      term = l || (m_cnt == MAXW);
      chk("len_err", len_err, term && !l);
      e.d = d; e.last = 1'b0; e.is_crc = 1'b0;
      q.push_back(e);
      m_run = m_crc(m_run, d);
      if (term) begin
         e.d = hand_en ? hand_crc : (m_run ^ XO);
         e.last = 1'b1; e.is_crc = 1'b1;
         q.push_back(e);
         m_run = 16'hFFFF;
         m_cnt = 0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (term) crc_pending = 1'b1;
   endtask

   task automatic drain(input int lim);
      int t;
      t = 0;
      while (q.size() != 0 && t < lim) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: got %0d pending beats expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor / scoreboard
   exp_t        me;
   logic        prev_stall = 1'b0;
   logic [15:0] p_d = 16'h0000;
   logic        p_l = 1'b0;
   logic        p_c = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
         r_run      = 16'hFFFF;
      end else begin
         if (prev_stall) begin
            chk("hold_data", out_data, p_d);
            chk("hold_flags", {out_valid, out_last, out_is_crc}, {1'b1, p_l, p_c});
         end
         if (crc_pending) begin
            if (out_valid && out_is_crc) crc_pending = 1'b0;
            else chk("in_ready_in_crc", in_ready, 1'b0);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat: got %h expected none", out_data);
            end else begin
               checks--;
               me = q.pop_front();
               chk("out_data", out_data, me.d);
               chk("out_flags", {out_last, out_is_crc}, {me.last, me.is_crc});
            end
            if (out_is_crc) begin
`ifdef CRC16_ENC_XOROUT_EN
               chk("crc_vs_observed", out_data, r_run ^ 16'hFFFF);
`else
               chk("residue", m_crc(r_run, out_data), 16'h0000);
`endif
               r_run = 16'hFFFF;
            end else begin
               r_run = m_crc(r_run, out_data);
            end
         end
         prev_stall = out_valid && !out_ready;
         p_d = out_data;
         p_l = out_last;
         p_c = out_is_crc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] fw [10] = '{16'h1234, 16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000,
                            16'h5555, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0};
   int          fl [4]  = '{1, 2, 3, 4};

   initial begin
      int idx;
      // Reset state
      #12;
      chk("rst_out_data", out_data, 16'h0000);
      chk("rst_flags", {out_valid, out_last, out_is_crc, len_err}, 4'b0000);
      chk("rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("in_ready_after_release", in_ready, 1'b1);

      // Hand-computed single-word frames
      send_word(16'h0000, 1'b1, 1'b1, HAND_Z);
      send_word(16'hFFFF, 1'b1, 1'b1, HAND_F);
      drain(100);

      // Frames of 1..4 words (last word of the 4-word frame hits MAX_WORDS and in_last)
      rdy_mode = 1;
      idx = 0;
      for (int f = 0; f < 4; f++) begin
         for (int w = 0; w < fl[f]; w++) begin
            send_word(fw[idx], (w == fl[f] - 1), 1'b0, 16'h0000);
            idx++;
         end
      end
      drain(500);

      // Six words without in_last: forced cut after word 4, words 5-6 form a new frame
      for (int w = 0; w < 6; w++)
         send_word(16'h1000 + 16'(w * 16'h0111), (w == 5), 1'b0, 16'h0000);
      drain(500);

      // Output stalled with a CRC pending
      rdy_mode = 2;
      send_word(16'h0F0F, 1'b1, 1'b0, 16'h0000);
      repeat (5) @(negedge clk);
      rdy_mode = 0;
      drain(100);

      // Reset after word 3 of a 5-word frame
      send_word(16'h1111, 1'b0, 1'b0, 16'h0000);
      send_word(16'h2222, 1'b0, 1'b0, 16'h0000);
      send_word(16'hABCD, 1'b0, 1'b0, 16'h0000);
      drain(100);
      #1;
      reset = 1'b0;
      #1;
      chk("arst_out_data", out_data, 16'h0000);
      chk("arst_flags", {out_valid, out_last, out_is_crc, len_err}, 4'b0000);
      chk("arst_in_ready", in_ready, 1'b0);
      m_run = 16'hFFFF;
      m_cnt = 0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      send_word(16'h0000, 1'b1, 1'b1, HAND_Z);
      drain(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
